chdr_deframer: RTL and testbench

// Receive side of the file_source CHDR packet stream. Parses each 64-bit CHDR

---
 rtl/chdr_deframer.sv | 168 ++++++++++++++++
 tb/tb_chdr_deframer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/chdr_deframer.sv
// rtl/chdr_deframer.sv - CHDR header/timestamp stripper with seq, length and SID checks
// Optional statistics counters behind CHDR_DEFRAMER_STATS_EN.
module chdr_deframer #(
    parameter logic [7:0] SR_SID_FILTER = 8'd128,
    parameter logic [7:0] SR_CLEAR      = 8'd129
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        set_stb,
    input  logic [7:0]  set_addr,
    input  logic [31:0] set_data,
    input  logic [63:0] i_tdata,
    input  logic        i_tlast,
    input  logic        i_tvalid,
    output logic        i_tready,
    output logic [63:0] o_tdata,
    output logic        o_tlast,
    output logic        o_tvalid,
    input  logic        o_tready,
    output logic [31:0] o_hdr_sid,
    output logic [11:0] o_hdr_seqnum,
    output logic        o_hdr_eob,
    output logic        o_hdr_has_time,
    output logic [63:0] o_hdr_time,
    output logic        seq_err,
    output logic        len_err,
    output logic        drop,
    output logic [63:0] rb_data
);
    typedef enum logic [1:0] {S_HDR, S_TIME, S_PAYLOAD, S_DROP} state_t;
    state_t state, state_nxt;

    logic        filt_en;
    logic [15:0] filt_sid;
    logic        seq_synced;
    logic [11:0] seq_expected;
    logic [15:0] beats, beat_cnt;

    logic        hdr_time;
    logic [11:0] hdr_seq;
    logic [15:0] hdr_len;
    logic [16:0] hdr_size, pay_bytes, pay_round;
    logic        hdr_short;
    logic [15:0] beats_calc;
    logic        clear_stb, hdr_acc, filtered, hdr_ok, pay_acc, pay_end;
    logic        unused_bits;

    assign hdr_time   = i_tdata[61];
    assign hdr_seq    = i_tdata[59:48];
    assign hdr_len    = i_tdata[47:32];
    assign hdr_size   = hdr_time ? 17'd16 : 17'd8;
    assign hdr_short  = {1'b0, hdr_len} < hdr_size;
    assign pay_bytes  = {1'b0, hdr_len} - hdr_size;
    assign pay_round  = pay_bytes + 17'd7;
    // A short length would underflow, so it is treated as an empty payload.
    assign beats_calc = hdr_short ? 16'd0 : {2'b00, pay_round[16:3]};

    assign clear_stb  = set_stb && (set_addr == SR_CLEAR);
    assign hdr_acc    = (state == S_HDR) && i_tvalid;
    assign filtered   = filt_en && (i_tdata[15:0] != filt_sid);
    assign hdr_ok     = hdr_acc && !filtered;
    assign pay_acc    = (state == S_PAYLOAD) && i_tvalid && o_tready;
    assign pay_end    = (beat_cnt == beats - 16'd1);
    assign unused_bits = &{1'b0, set_data[31:17], i_tdata[63:62]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_HDR;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_HDR: if (i_tvalid) begin
                if (i_tlast)                 state_nxt = S_HDR;
                else if (filtered)           state_nxt = S_DROP;
                else if (hdr_time)           state_nxt = S_TIME;
                else if (beats_calc == 16'd0) state_nxt = S_DROP;
                else                         state_nxt = S_PAYLOAD;
            end
            S_TIME: if (i_tvalid) begin
                if (i_tlast)                 state_nxt = S_HDR;
                else if (beats == 16'd0)     state_nxt = S_DROP;
                else                         state_nxt = S_PAYLOAD;
            end
            S_PAYLOAD: if (pay_acc && (i_tlast || pay_end))
                state_nxt = i_tlast ? S_HDR : S_DROP;
            S_DROP: if (i_tvalid && i_tlast) state_nxt = S_HDR;
            default: state_nxt = S_HDR;
        endcase
    end

    always_comb begin
        i_tready = 1'b1;
        o_tvalid = 1'b0;
        o_tdata  = 64'd0;
        o_tlast  = 1'b0;
        if (state == S_PAYLOAD) begin
            i_tready = o_tready;
            o_tvalid = i_tvalid;
            o_tdata  = i_tdata;
            o_tlast  = i_tlast || pay_end;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_en        <= 1'b0;
            filt_sid       <= 16'd0;
            seq_synced     <= 1'b0;
            seq_expected   <= 12'd0;
            beats          <= 16'd0;
            beat_cnt       <= 16'd0;
            o_hdr_sid      <= 32'd0;
            o_hdr_seqnum   <= 12'd0;
            o_hdr_eob      <= 1'b0;
            o_hdr_has_time <= 1'b0;
            o_hdr_time     <= 64'd0;
            seq_err        <= 1'b0;
            len_err        <= 1'b0;
            drop           <= 1'b0;
        end else begin
            // A clear in the same cycle as a header suppresses the check.
            seq_err <= hdr_ok && seq_synced && !clear_stb && (hdr_seq != seq_expected);
            len_err <= (hdr_ok && hdr_short) || (pay_acc && (i_tlast != pay_end));
            drop    <= hdr_acc && filtered;
            if (set_stb && set_addr == SR_SID_FILTER) begin
                filt_en  <= set_data[16];
                filt_sid <= set_data[15:0];
            end
            if (hdr_ok) begin
                o_hdr_sid      <= i_tdata[31:0];
                o_hdr_seqnum   <= hdr_seq;
                o_hdr_eob      <= i_tdata[60];
                o_hdr_has_time <= hdr_time;
                seq_synced     <= 1'b1;
                seq_expected   <= hdr_seq + 12'd1;
                beats          <= beats_calc;
                beat_cnt       <= 16'd0;
            end else if (clear_stb) begin
                seq_synced <= 1'b0;
            end
            if (state == S_TIME && i_tvalid) o_hdr_time <= i_tdata;
            if (pay_acc) beat_cnt <= beat_cnt + 16'd1;
        end
    end

`ifdef CHDR_DEFRAMER_STATS_EN
    logic [31:0] pkt_cnt, err_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_cnt <= 32'd0;
            err_cnt <= 32'd0;
        end else if (clear_stb) begin
            pkt_cnt <= 32'd0;
            err_cnt <= 32'd0;
        end else begin
            if (hdr_ok && pkt_cnt != 32'hFFFF_FFFF) pkt_cnt <= pkt_cnt + 32'd1;
            if ((seq_err || len_err) && err_cnt != 32'hFFFF_FFFF) err_cnt <= err_cnt + 32'd1;
        end
    end

    assign rb_data = {pkt_cnt, err_cnt};
`else
    assign rb_data = 64'd0;
`endif
endmodule

// File: tb/tb_chdr_deframer.sv
// tb/tb_chdr_deframer.sv - randomized self-checking bench for chdr_deframer
module tb_chdr_deframer;
    logic        clk = 1'b0;
    logic        reset;
    logic        set_stb;
    logic [7:0]  set_addr;
    logic [31:0] set_data;
    logic [63:0] i_tdata;
    logic        i_tlast, i_tvalid, i_tready;
    logic [63:0] o_tdata;
    logic        o_tlast, o_tvalid, o_tready;
    logic [31:0] o_hdr_sid;
    logic [11:0] o_hdr_seqnum;
    logic        o_hdr_eob, o_hdr_has_time;
    logic [63:0] o_hdr_time;
    logic        seq_err, len_err, drop;
    logic [63:0] rb_data;

    chdr_deframer dut (
        .clk(clk), .reset(reset), .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
        .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
        .o_hdr_sid(o_hdr_sid), .o_hdr_seqnum(o_hdr_seqnum), .o_hdr_eob(o_hdr_eob),
        .o_hdr_has_time(o_hdr_has_time), .o_hdr_time(o_hdr_time),
        .seq_err(seq_err), .len_err(len_err), .drop(drop), .rb_data(rb_data)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    logic [64:0] got_q[$], exp_q[$];
    int n_seq = 0, n_len = 0, n_drop = 0;
    int m_seq = 0, m_len = 0, m_drop = 0, m_pkt = 0, m_err = 0, m_exp = 0;
    bit m_synced = 0, m_fen = 0;
    logic [15:0] m_fsid = 16'd0;
    logic [31:0] m_sid = 32'd0;
    logic [11:0] m_seqnum = 12'd0;
    logic        m_eob = 1'b0, m_ht = 1'b0;
    logic [63:0] m_time = 64'd0;
    bit rnd_ready = 0;

    initial begin
        o_tready = 1'b1;
        forever begin
            @(posedge clk); #1;
            o_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (o_tvalid && o_tready) got_q.push_back({o_tlast, o_tdata});
            if (seq_err) n_seq++;
            if (len_err) n_len++;
            if (drop) n_drop++;
        end
    end

    function automatic logic [63:0] exp_rb();
`ifdef CHDR_DEFRAMER_STATS_EN
        return {32'(m_pkt), 32'(m_err)};
`else
        return 64'd0;
`endif
    endfunction

    task automatic send_word(input logic [63:0] d, input bit last);
        logic rdy;
        if ($urandom_range(0, 3) == 0) begin
            i_tvalid = 1'b0;
            @(posedge clk); #1;
        end
        i_tvalid = 1'b1; i_tdata = d; i_tlast = last;
        rdy = 1'b0;
        for (int k = 0; k < 1000 && !rdy; k++) begin
            @(negedge clk); rdy = i_tready;
            @(posedge clk); #1;
        end
        if (!rdy) begin
            tests++; fails++;
            $display("FAIL handshake_timeout got i_tready=0 want 1 within 1000 cycles");
        end
    endtask

    task automatic set_reg(input logic [7:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        set_stb = 1'b1; set_addr = a; set_data = d;
        @(posedge clk); #1;
        set_stb = 1'b0;
        if (a == 8'd128) begin m_fen = d[16]; m_fsid = d[15:0]; end
        if (a == 8'd129) begin m_synced = 0; m_pkt = 0; m_err = 0; end
    endtask

    // Drives one packet and updates the reference model from the packet-level rules.
    task automatic run_pkt(input bit ht, input bit eob, input logic [11:0] seq, input logic [15:0] len,
                           input logic [31:0] sid, input logic [63:0] tm, input int np);
        logic [63:0] pay[$];
        int hs, beats, nout;
        bit short_len, bad_seq;
        for (int i = 0; i < np; i++) pay.push_back({$urandom, $urandom});
        if (m_fen && sid[15:0] != m_fsid) begin
            m_drop++;
        end else begin
            hs = ht ? 16 : 8;
            short_len = int'(len) < hs;
            beats = short_len ? 0 : (int'(len) - hs + 7) / 8;
            bad_seq = m_synced && (int'(seq) != m_exp);
            if (bad_seq) m_seq++;
            if (short_len) m_len++;
            if (bad_seq || short_len) m_err++;
            m_exp = (int'(seq) + 1) % 4096; m_synced = 1;
            m_sid = sid; m_seqnum = seq; m_eob = eob; m_ht = ht;
            if (ht) m_time = tm;
            m_pkt++;
            if (beats > 0) begin
                nout = (np < beats) ? np : beats;
                for (int i = 0; i < nout; i++) exp_q.push_back({i == nout - 1, pay[i]});
                if (np != beats) begin m_len++; m_err++; end
            end
        end
        send_word({2'b00, ht, eob, seq, len, sid}, !ht && np == 0);
        if (ht) send_word(tm, np == 0);
        for (int i = 0; i < np; i++) send_word(pay[i], i == np - 1);
        i_tvalid = 1'b0; i_tlast = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; set_stb = 1'b0; set_addr = 8'd0; set_data = 32'd0;
        i_tdata = 64'hDEAD_BEEF_0000_0001; i_tlast = 1'b0; i_tvalid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++; if (o_tvalid !== 1'b0) begin fails++; $display("FAIL reset_o_tvalid got %b want 0", o_tvalid); end
        tests++; if (o_tdata !== 64'd0) begin fails++; $display("FAIL reset_o_tdata got %h want 0", o_tdata); end
        tests++; if (i_tready !== 1'b1) begin fails++; $display("FAIL reset_i_tready got %b want 1", i_tready); end
        tests++; if ({o_hdr_sid, o_hdr_seqnum, o_hdr_time} !== 108'd0) begin fails++; $display("FAIL reset_sideband got %h want 0", {o_hdr_sid, o_hdr_seqnum, o_hdr_time}); end
        tests++; if ({seq_err, len_err, drop} !== 3'b000) begin fails++; $display("FAIL reset_pulses got %b want 000", {seq_err, len_err, drop}); end
        tests++; if (rb_data !== 64'd0) begin fails++; $display("FAIL reset_rb_data got %h want 0", rb_data); end
        i_tdata = 64'd0;
        @(posedge clk); #1; reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        for (int s = 0; s < 4; s++) run_pkt(0, s == 3, 12'(s), 16'd40, 32'h0001_1234, 64'd0, 4);
        tests++; if (got_q.size() != 16) begin fails++; $display("FAIL basic_count got %0d want 16", got_q.size()); end
        tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL basic_qsize got %0d want %0d", got_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            tests++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL basic_beat%0d got %h want %h", i, got_q[i], exp_q[i]); end
        end
        tests++; if (n_seq != 0 || n_len != 0) begin fails++; $display("FAIL basic_errs got seq=%0d len=%0d want 0 0", n_seq, n_len); end
        tests++; if ({o_hdr_sid, o_hdr_seqnum, o_hdr_eob} !== {m_sid, m_seqnum, m_eob}) begin fails++; $display("FAIL basic_sideband got %h want %h", {o_hdr_sid, o_hdr_seqnum, o_hdr_eob}, {m_sid, m_seqnum, m_eob}); end
        tests++; if (rb_data !== exp_rb()) begin fails++; $display("FAIL basic_rb got %h want %h", rb_data, exp_rb()); end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_time();
        run_pkt(1, 0, 12'd4, 16'd48, 32'h0002_0077, 64'h1234, 4);
        tests++; if (o_hdr_time !== 64'h1234) begin fails++; $display("FAIL time_value got %h want 1234", o_hdr_time); end
        tests++; if (o_hdr_has_time !== 1'b1) begin fails++; $display("FAIL time_flag got %b want 1", o_hdr_has_time); end
        run_pkt(0, 0, 12'd5, 16'd16, 32'h0002_0077, 64'h9999, 1);
        tests++; if (o_hdr_time !== m_time) begin fails++; $display("FAIL time_hold got %h want %h", o_hdr_time, m_time); end
        tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL time_qsize got %0d want %0d", got_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            tests++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL time_beat%0d got %h want %h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_seq();
        set_reg(8'd129, 32'd0);
        run_pkt(0, 0, 12'd5, 16'd16, 32'h10, 64'd0, 1);
        run_pkt(0, 0, 12'd7, 16'd16, 32'h10, 64'd0, 1);
        run_pkt(0, 0, 12'd8, 16'd16, 32'h10, 64'd0, 1);
        tests++; if (n_seq != m_seq) begin fails++; $display("FAIL seq_err_count got %0d want %0d", n_seq, m_seq); end
        tests++; if (n_len != m_len) begin fails++; $display("FAIL seq_len_count got %0d want %0d", n_len, m_len); end
        tests++; if (rb_data !== exp_rb()) begin fails++; $display("FAIL seq_rb got %h want %h", rb_data, exp_rb()); end
        tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL seq_qsize got %0d want %0d", got_q.size(), exp_q.size()); end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_length();
        run_pkt(0, 0, 12'd9, 16'd40, 32'h10, 64'd0, 2);
        run_pkt(0, 0, 12'd10, 16'd24, 32'h10, 64'd0, 4);
        run_pkt(0, 0, 12'd11, 16'd4, 32'h10, 64'd0, 1);
        run_pkt(0, 0, 12'd12, 16'd8, 32'h10, 64'd0, 1);
        run_pkt(1, 0, 12'd13, 16'd12, 32'h10, 64'h55, 2);
        tests++; if (n_len != m_len) begin fails++; $display("FAIL len_err_count got %0d want %0d", n_len, m_len); end
        tests++; if (n_seq != m_seq) begin fails++; $display("FAIL len_seq_count got %0d want %0d", n_seq, m_seq); end
        tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL len_qsize got %0d want %0d", got_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            tests++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL len_beat%0d got %h want %h", i, got_q[i], exp_q[i]); end
        end
        tests++; if (rb_data !== exp_rb()) begin fails++; $display("FAIL len_rb got %h want %h", rb_data, exp_rb()); end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_filter();
        set_reg(8'd128, {15'd0, 1'b1, 16'h0010});
        run_pkt(0, 1, 12'(m_exp), 16'd40, 32'h0000_0020, 64'd0, 4);
        tests++; if (n_drop != m_drop) begin fails++; $display("FAIL filter_drop got %0d want %0d", n_drop, m_drop); end
        tests++; if (o_hdr_sid !== m_sid) begin fails++; $display("FAIL filter_sid_hold got %h want %h", o_hdr_sid, m_sid); end
        run_pkt(0, 0, 12'(m_exp), 16'd40, 32'h0003_0010, 64'd0, 4);
        tests++; if (n_seq != m_seq) begin fails++; $display("FAIL filter_seq got %0d want %0d", n_seq, m_seq); end
        tests++; if (o_hdr_sid !== m_sid) begin fails++; $display("FAIL filter_sid_pass got %h want %h", o_hdr_sid, m_sid); end
        tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL filter_qsize got %0d want %0d", got_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            tests++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL filter_beat%0d got %h want %h", i, got_q[i], exp_q[i]); end
        end
        set_reg(8'd128, 32'd0);
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        bit ht;
        int np;
        logic [15:0] len;
        logic [11:0] seq;
        set_reg(8'd129, 32'd0);
        rnd_ready = 1;
        run_pkt(0, 0, 12'd4094, 16'd32, 32'h44, 64'd0, 3);
        run_pkt(0, 0, 12'd4095, 16'd32, 32'h44, 64'd0, 3);
        run_pkt(0, 0, 12'd0, 16'd32, 32'h44, 64'd0, 3);
        tests++; if (n_seq != m_seq) begin fails++; $display("FAIL wrap_seq got %0d want %0d", n_seq, m_seq); end
        for (int p = 0; p < 30; p++) begin
            ht = 1'($urandom_range(0, 1));
            np = $urandom_range(1, 8);
            if ($urandom_range(0, 1) == 0) len = 16'(8 + (ht ? 8 : 0) + 8 * np - $urandom_range(0, 7));
            else len = 16'($urandom_range(0, 80));
            seq = ($urandom_range(0, 4) == 0) ? 12'($urandom) : 12'(m_exp);
            run_pkt(ht, 1'($urandom_range(0, 1)), seq, len, $urandom, {$urandom, $urandom}, np);
        end
        rnd_ready = 0;
        tests++; if (n_seq != m_seq) begin fails++; $display("FAIL rand_seq got %0d want %0d", n_seq, m_seq); end
        tests++; if (n_len != m_len) begin fails++; $display("FAIL rand_len got %0d want %0d", n_len, m_len); end
        tests++; if ({o_hdr_sid, o_hdr_seqnum, o_hdr_time} !== {m_sid, m_seqnum, m_time}) begin fails++; $display("FAIL rand_sideband got %h want %h", {o_hdr_sid, o_hdr_seqnum, o_hdr_time}, {m_sid, m_seqnum, m_time}); end
        tests++; if (rb_data !== exp_rb()) begin fails++; $display("FAIL rand_rb got %h want %h", rb_data, exp_rb()); end
        tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL rand_qsize got %0d want %0d", got_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            tests++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL rand_beat%0d got %h want %h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_time();
        test_seq();
        test_length();
        test_filter();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
